// File: rtl/dcache_pkg.sv
// Shared types and address-field width helper for the two-way data cache.
package dcache_pkg;

    // Widest tag any supported geometry needs; narrower tags are zero-extended.
    localparam int TAG_MAX = 32;

    localparam int FLD_OFF = 0;
    localparam int FLD_IDX = 1;
    localparam int FLD_TAG = 2;

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        READMISS,
        FILL
    } state_t;

    typedef struct packed {
        logic               valid;
        logic               dirty;
        logic [TAG_MAX-1:0] tag;
    } way_entry_t;

    function automatic int field_w(input int fld, input int addr_w, input int line_w,
                                   input int sets);
        int off_w;
        int idx_w;
        off_w = $clog2(line_w / 8);
        idx_w = $clog2(sets);
        case (fld)
            FLD_OFF: return off_w;
            FLD_IDX: return idx_w;
            default: return addr_w - off_w - idx_w;
        endcase
    endfunction

endpackage

// File: rtl/dcache_way.sv
// One cache way: tag/valid/dirty and line storage, async read, sync full-line or word write.
module dcache_way
    import dcache_pkg::*;
#(
    parameter int LINE_W = 256,
    parameter int SETS   = 32
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [$clog2(SETS)-1:0]                rd_idx,
    input  logic [$clog2(SETS)-1:0]                wr_idx,
    input  logic                                   line_we,
    input  logic                                   word_we,
    input  logic [$clog2(LINE_W/8)-3:0]            word_sel,
    input  logic [31:0]                            wr_word,
    input  logic [LINE_W-1:0]                      wr_line,
    input  logic [TAG_MAX-1:0]                     wr_tag,
    output way_entry_t                             entry,
    output logic [LINE_W-1:0]                      line
);

    logic [SETS-1:0]    valid_q;
    logic [SETS-1:0]    dirty_q;
    logic [TAG_MAX-1:0] tag_q  [SETS];
    logic [LINE_W-1:0]  line_q [SETS];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we) begin
            valid_q[wr_idx] <= 1'b1;
            dirty_q[wr_idx] <= 1'b0;
        end else if (word_we) begin
            dirty_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (line_we) begin
            tag_q[wr_idx]  <= wr_tag;
            line_q[wr_idx] <= wr_line;
        end else if (word_we) begin
            line_q[wr_idx][{word_sel, 5'b0} +: 32] <= wr_word;
        end
    end

    assign entry.valid = valid_q[rd_idx];
    assign entry.dirty = dirty_q[rd_idx];
    assign entry.tag   = tag_q[rd_idx];
    assign line        = line_q[rd_idx];

endmodule

// File: rtl/dcache_assoc.sv
// Two-way set-associative write-back data cache with per-set LRU.
// Optional hit/miss/write-back counters when DCACHE_STATS_EN is defined.
//   state     | meaning
//   IDLE      | serve hits, detect miss
//   MISS      | latch victim, start write-back or fill
//   WRITEBACK | dirty victim going to memory
//   READMISS  | waiting for fill line
//   FILL      | line installed, request retried next cycle
module dcache_assoc
    import dcache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [31:0]       p1_data_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o,
    output logic [31:0]       wb_cnt_o
`endif
);

    localparam int OFF_W  = field_w(FLD_OFF, ADDR_W, LINE_W, SETS);
    localparam int IDX_W  = field_w(FLD_IDX, ADDR_W, LINE_W, SETS);
    localparam int TAG_W  = field_w(FLD_TAG, ADDR_W, LINE_W, SETS);
    localparam int WSEL_W = OFF_W - 2;

    state_t            state_q, state_d;
    logic              req;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WSEL_W-1:0] req_word;
    way_entry_t        entry [2];
    logic [LINE_W-1:0] line  [2];
    logic [1:0]        tag_hit;
    logic              hit, hit_way, store_hit, fill_we;
    logic [SETS-1:0]   lru_q;
    logic              victim_q, victim_d;
    logic [IDX_W-1:0]  idx_q;
    logic [TAG_W-1:0]  tag_q;
    logic [LINE_W-1:0] mem_data_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic              mem_enable_d, mem_write_d;
    logic              unused_addr;

    assign req         = p1_MemRead_i | p1_MemWrite_i;
    assign req_tag     = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign req_idx     = p1_addr_i[OFF_W +: IDX_W];
    assign req_word    = p1_addr_i[OFF_W-1:2];
    assign unused_addr = ^p1_addr_i[1:0];

    for (genvar w = 0; w < 2; w++) begin : g_way
        assign tag_hit[w] = entry[w].valid && (entry[w].tag == TAG_MAX'(req_tag));

        dcache_way #(.LINE_W(LINE_W), .SETS(SETS)) u_way (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .rd_idx   (req_idx),
            .wr_idx   (fill_we ? idx_q : req_idx),
            .line_we  (fill_we && (victim_q == 1'(w))),
            .word_we  (store_hit && (hit_way == 1'(w))),
            .word_sel (req_word),
            .wr_word  (p1_data_i),
            .wr_line  (mem_data_i),
            .wr_tag   (TAG_MAX'(tag_q)),
            .entry    (entry[w]),
            .line     (line[w])
        );
    end

    // Hits are only served from IDLE so a retried request completes exactly once.
    assign hit        = req && (state_q == IDLE) && (|tag_hit);
    assign hit_way    = tag_hit[1];
    assign store_hit  = hit && p1_MemWrite_i;
    assign fill_we    = (state_q == READMISS) && mem_ack_i;
    assign p1_stall_o = req & ~hit;
    assign p1_data_o  = line[hit_way][{req_word, 5'b0} +: 32];

    always_comb begin
        if (!entry[0].valid)      victim_d = 1'b0;
        else if (!entry[1].valid) victim_d = 1'b1;
        else                      victim_d = lru_q[req_idx];
    end

    always_comb begin
        state_d      = state_q;
        mem_data_d   = mem_data_o;
        mem_addr_d   = mem_addr_o;
        mem_enable_d = mem_enable_o;
        mem_write_d  = mem_write_o;
        unique case (state_q)
            IDLE: begin
                if (req && !hit) state_d = MISS;
            end
            MISS: begin
                mem_enable_d = 1'b1;
                if (entry[victim_d].valid && entry[victim_d].dirty) begin
                    mem_data_d  = line[victim_d];
                    mem_addr_d  = {entry[victim_d].tag[TAG_W-1:0], req_idx, OFF_W'(0)};
                    mem_write_d = 1'b1;
                    state_d     = WRITEBACK;
                end else begin
                    mem_addr_d  = {req_tag, req_idx, OFF_W'(0)};
                    mem_write_d = 1'b0;
                    state_d     = READMISS;
                end
            end
            WRITEBACK: begin
                if (mem_ack_i) begin
                    mem_addr_d  = {tag_q, idx_q, OFF_W'(0)};
                    mem_write_d = 1'b0;
                    state_d     = READMISS;
                end
            end
            READMISS: begin
                if (mem_ack_i) begin
                    mem_enable_d = 1'b0;
                    state_d      = FILL;
                end
            end
            FILL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            mem_data_o   <= '0;
            mem_addr_o   <= '0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            lru_q        <= '0;
            victim_q     <= 1'b0;
            idx_q        <= '0;
            tag_q        <= '0;
        end else begin
            state_q      <= state_d;
            mem_data_o   <= mem_data_d;
            mem_addr_o   <= mem_addr_d;
            mem_enable_o <= mem_enable_d;
            mem_write_o  <= mem_write_d;
            if (state_q == MISS) begin
                victim_q <= victim_d;
                idx_q    <= req_idx;
                tag_q    <= req_tag;
            end
            if (hit) lru_q[req_idx] <= ~hit_way;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            if (hit && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 32'd1;
            if ((state_q == IDLE) && (state_d == MISS) && (miss_cnt_q != '1))
                miss_cnt_q <= miss_cnt_q + 32'd1;
            if ((state_q == MISS) && (state_d == WRITEBACK) && (wb_cnt_q != '1))
                wb_cnt_q <= wb_cnt_q + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
    assign wb_cnt_o   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_assoc.sv
// Scoreboard bench for dcache_assoc: expected memory transactions and load data are queued
// at stimulus time and checked when the memory model acks or the stall releases.
module tb_dcache_assoc;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic [255:0] mem_data_o;
    logic [31:0]  mem_addr_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  p1_data_i = '0;
    logic [31:0]  p1_addr_i = '0;
    logic         p1_MemRead_i = 1'b0;
    logic         p1_MemWrite_i = 1'b0;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt_o, miss_cnt_o, wb_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    dcache_assoc dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i),
        .mem_data_o    (mem_data_o),
        .mem_addr_o    (mem_addr_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .p1_data_i     (p1_data_i),
        .p1_addr_i     (p1_addr_i),
        .p1_MemRead_i  (p1_MemRead_i),
        .p1_MemWrite_i (p1_MemWrite_i),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o     (hit_cnt_o),
        .miss_cnt_o    (miss_cnt_o),
        .wb_cnt_o      (wb_cnt_o)
`endif
    );

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } txn_t;

    int           vectors = 0;
    int           miscompares = 0;
    int           lat_w = 2;
    int           lat_r = 2;
    txn_t         exp_txn[$];
    logic [31:0]  exp_rd[$];
    logic [255:0] mem [logic [31:0]];

    function automatic logic [255:0] gen_line(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++)
            l[i*32 +: 32] = (a == 32'h40) ? 32'hA5A5_0001 + i : {a[15:0], 16'h0} + i;
        return l;
    endfunction

    function automatic logic [255:0] rd_mem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return gen_line(a);
    endfunction

    function automatic logic [255:0] put_word(input logic [255:0] l, input int w,
                                              input logic [31:0] v);
        logic [255:0] r;
        r = l;
        r[w*32 +: 32] = v;
        return r;
    endfunction

    task automatic push_txn(input bit wr, input logic [31:0] addr, input logic [255:0] data);
        txn_t t;
        t.wr = wr;
        t.addr = addr;
        t.data = data;
        exp_txn.push_back(t);
    endtask

    // Memory model: acks after lat_w / lat_r cycles of enable in each phase.
    initial begin : responder
        int   cnt;
        txn_t e;
        cnt = 0;
        mem_ack_i = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            if (!rst_i || !mem_enable_o) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt >= (mem_write_o ? lat_w : lat_r)) begin
                    cnt = 0;
                    mem_ack_i = 1'b1;
                    vectors++;
                    if (exp_txn.size() == 0) begin
                        miscompares++;
                        $display("FAIL mem_txn: got wr=%0b addr=%h, required no transaction",
                                 mem_write_o, mem_addr_o);
                    end else begin
                        e = exp_txn.pop_front();
                        if (mem_write_o !== e.wr || mem_addr_o !== e.addr ||
                            (e.wr && mem_data_o !== e.data)) begin
                            miscompares++;
                            $display("FAIL mem_txn: got wr=%0b addr=%h data=%h, required wr=%0b addr=%h data=%h",
                                     mem_write_o, mem_addr_o, mem_data_o, e.wr, e.addr, e.data);
                        end
                    end
                    if (mem_write_o) mem[mem_addr_o] = mem_data_o;
                    else             mem_data_i = rd_mem(mem_addr_o);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the completing edge.
    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int exp_stall, input int exp_rises,
                          input string name);
        int          cycles;
        int          rises;
        bit          prev_en;
        logic [31:0] e;
        p1_addr_i     = addr;
        p1_data_i     = wdata;
        p1_MemWrite_i = wr;
        p1_MemRead_i  = !wr;
        if (!wr) exp_rd.push_back(rdata);
        cycles  = 0;
        rises   = 0;
        prev_en = mem_enable_o;
        @(negedge clk_i);
        while (p1_stall_o === 1'b1 && cycles < 200) begin
            cycles++;
            @(negedge clk_i);
            if (mem_enable_o && !prev_en) rises++;
            prev_en = mem_enable_o;
        end
        vectors++;
        if (cycles != exp_stall) begin
            miscompares++;
            $display("FAIL %s stall_cycles: got %0d, required %0d", name, cycles, exp_stall);
        end
        vectors++;
        if (rises != exp_rises) begin
            miscompares++;
            $display("FAIL %s enable_bursts: got %0d, required %0d", name, rises, exp_rises);
        end
        if (!wr) begin
            e = exp_rd.pop_front();
            vectors++;
            if (p1_data_o !== e) begin
                miscompares++;
                $display("FAIL %s load_data: got %h, required %h", name, p1_data_o, e);
            end
        end
        @(posedge clk_i);
        #1;
        p1_MemRead_i  = 1'b0;
        p1_MemWrite_i = 1'b0;
    endtask

    task automatic check_drained(input string name);
        vectors++;
        if (exp_txn.size() != 0) begin
            miscompares++;
            $display("FAIL %s pending_txns: got %0d outstanding, required 0", name, exp_txn.size());
        end
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got en=%b wr=%b, required 0 0", mem_enable_o, mem_write_o);
        end
        vectors++;
        if (mem_addr_o !== 32'h0 || mem_data_o !== 256'h0) begin
            miscompares++;
            $display("FAIL reset_regs: got addr=%h data=%h, required 0", mem_addr_o, mem_data_o);
        end
        vectors++;
        if (p1_stall_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_stall_idle: got %b, required 0", p1_stall_o);
        end
        p1_addr_i = 32'h40;
        p1_MemRead_i = 1'b1;
        #1;
        vectors++;
        if (p1_stall_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_stall_req: got %b, required 1", p1_stall_o);
        end
        p1_MemRead_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_clean_miss();
        lat_r = 2;
        push_txn(1'b0, 32'h40, '0);
        access(1'b0, 32'h40, '0, 32'hA5A5_0001, 3 + lat_r, 1, "clean_miss_40");
        check_drained("clean_miss");
    endtask

    task automatic test_write_hit();
        access(1'b1, 32'h44, 32'hDEAD_BEEF, '0, 0, 0, "store_hit_44");
        access(1'b0, 32'h44, '0, 32'hDEAD_BEEF, 0, 0, "load_44");
        access(1'b0, 32'h48, '0, 32'hA5A5_0003, 0, 0, "load_48");
        access(1'b0, 32'h40, '0, 32'hA5A5_0001, 0, 0, "load_40");
        check_drained("write_hit");
    endtask

    task automatic test_lru();
        lat_r = 3;
        push_txn(1'b0, 32'h440, '0);
        access(1'b0, 32'h440, '0, 32'h0440_0000, 3 + lat_r, 1, "fill_440");
        access(1'b0, 32'h40, '0, 32'hA5A5_0001, 0, 0, "touch_40");
        push_txn(1'b0, 32'h840, '0);
        access(1'b0, 32'h840, '0, 32'h0840_0000, 3 + lat_r, 1, "evict_440");
        access(1'b0, 32'h40, '0, 32'hDEAD_BEEF & 32'h0 | 32'hA5A5_0001, 0, 0, "keep_40");
        push_txn(1'b0, 32'h440, '0);
        access(1'b0, 32'h444, '0, 32'h0440_0001, 3 + lat_r, 1, "refetch_440");
        check_drained("lru");
    endtask

    task automatic test_dirty_writeback();
        lat_w = 2;
        lat_r = 3;
        access(1'b1, 32'h448, 32'h1234_5678, '0, 0, 0, "store_448");
        access(1'b0, 32'h40, '0, 32'hA5A5_0001, 0, 0, "touch_40b");
        push_txn(1'b1, 32'h440, put_word(gen_line(32'h440), 2, 32'h1234_5678));
        push_txn(1'b0, 32'h840, '0);
        access(1'b0, 32'h840, '0, 32'h0840_0000, 3 + lat_w + lat_r, 1, "dirty_miss_840");
        check_drained("dirty_writeback");
    endtask

    task automatic test_reset_mid_wb();
        int n;
        lat_w = 4;
        lat_r = 2;
        push_txn(1'b1, 32'h40, put_word(gen_line(32'h40), 1, 32'hDEAD_BEEF));
        p1_addr_i = 32'hC40;
        p1_MemRead_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (mem_write_o !== 1'b1 && n < 20);
        vectors++;
        if (mem_write_o !== 1'b1) begin
            miscompares++;
            $display("FAIL wb_entry: got wr=%b, required 1", mem_write_o);
        end
        #1;
        rst_i = 1'b0;
        #1;
        vectors++;
        if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_wb: got en=%b wr=%b, required 0 0", mem_enable_o, mem_write_o);
        end
        exp_txn.delete();
        p1_MemRead_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        push_txn(1'b0, 32'h40, '0);
        access(1'b0, 32'h40, '0, 32'hA5A5_0001, 3 + lat_r, 1, "miss_after_reset");
        check_drained("reset_mid_wb");
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats();
        logic [31:0] h0, m0, w0;
        h0 = hit_cnt_o;
        m0 = miss_cnt_o;
        w0 = wb_cnt_o;
        access(1'b1, 32'h44, 32'h55AA_55AA, '0, 0, 0, "stats_hit");
        push_txn(1'b0, 32'h440, '0);
        access(1'b0, 32'h440, '0, 32'h0440_0000, 3 + lat_r, 1, "stats_clean");
        push_txn(1'b1, 32'h40, put_word(rd_mem(32'h40), 1, 32'h55AA_55AA));
        push_txn(1'b0, 32'h840, '0);
        access(1'b0, 32'h840, '0, 32'h0840_0000, 3 + lat_w + lat_r, 1, "stats_dirty");
        vectors++;
        if (hit_cnt_o - h0 !== 32'd3 || miss_cnt_o - m0 !== 32'd2 || wb_cnt_o - w0 !== 32'd1) begin
            miscompares++;
            $display("FAIL stats_delta: got hit=%0d miss=%0d wb=%0d, required 3 2 1",
                     hit_cnt_o - h0, miss_cnt_o - m0, wb_cnt_o - w0);
        end
        force dut.hit_cnt_q  = 32'hFFFF_FFFF;
        force dut.miss_cnt_q = 32'hFFFF_FFFF;
        force dut.wb_cnt_q   = 32'hFFFF_FFFF;
        @(negedge clk_i);
        release dut.hit_cnt_q;
        release dut.miss_cnt_q;
        release dut.wb_cnt_q;
        @(posedge clk_i);
        #1;
        access(1'b1, 32'h444, 32'h0BAD_CAFE, '0, 0, 0, "sat_store");
        access(1'b0, 32'h840, '0, 32'h0840_0000, 0, 0, "sat_touch");
        push_txn(1'b1, 32'h440, put_word(rd_mem(32'h440), 1, 32'h0BAD_CAFE));
        push_txn(1'b0, 32'h40, '0);
        access(1'b0, 32'h40, '0, rd_mem(32'h40) & 32'hFFFF_FFFF | 32'h0, 3 + lat_w + lat_r, 1,
               "sat_dirty");
        vectors++;
        if (hit_cnt_o !== 32'hFFFF_FFFF || miss_cnt_o !== 32'hFFFF_FFFF ||
            wb_cnt_o !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL stats_saturate: got hit=%h miss=%h wb=%h, required ffffffff",
                     hit_cnt_o, miss_cnt_o, wb_cnt_o);
        end
        check_drained("stats");
    endtask
`endif

    initial begin
        test_reset();
        test_clean_miss();
        test_write_hit();
        test_lru();
        test_dirty_writeback();
        test_reset_mid_wb();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
